// File: rtl/srambank_rmw_ctrl.sv
// srambank_rmw_ctrl: single-outstanding request controller for a 1024x64
// synchronous SRAM bank; byte-masked writes become read-modify-write.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid_i/ready_o    request handshake
//   req_write_i            1 = write, 0 = read
//   req_addr_i             word address
//   req_wdata_i            write data
//   req_wmask_i            byte enables (writes only)
//   rsp_valid_o/ready_i    read response handshake
//   rsp_rdata_o            read data
//   sram_addr_o            bank address
//   sram_wd_o              bank write data
//   sram_banksel_o         bank select (read or write strobe active)
//   sram_read_o            bank read strobe
//   sram_write_o           bank write strobe
//   sram_dataout_i         bank read data (held until the next read)
//
// Optional feature macro: SRAMCTL_FULLWR_BYPASS_EN
//   defined   -> full-mask writes skip the read and go straight to WR
//   undefined -> every non-zero-mask write runs RD then MERGE

module srambank_rmw_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_write_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_wmask_i,

    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,

    output logic [ADDR_W-1:0]   sram_addr_o,
    output logic [DATA_W-1:0]   sram_wd_o,
    output logic                sram_banksel_o,
    output logic                sram_read_o,
    output logic                sram_write_o,
    input  logic [DATA_W-1:0]   sram_dataout_i
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RESP,
        S_MERGE,
        S_WR
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                write_q, write_d;

    logic                accept;
    logic                mask_zero;
    logic                mask_full;
    logic [DATA_W-1:0]   merged;

    assign accept    = req_valid_i & req_ready_o;
    assign mask_zero = ~|req_wmask_i;
    assign mask_full = &req_wmask_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            write_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        write_d = write_q;
        if (accept) begin
            addr_d  = req_addr_i;
            wdata_d = req_wdata_i;
            wmask_d = req_wmask_i;
            write_d = req_write_i;
        end
    end

    // Byte merge: new bytes where enabled, old bank bytes elsewhere.
    // sram_dataout_i still holds the word fetched by the preceding RD.
    always_comb begin
        merged = '0;
        for (int i = 0; i < MASK_W; i++) begin
            merged[8*i +: 8] = wmask_q[i] ? wdata_q[8*i +: 8]
                                          : sram_dataout_i[8*i +: 8];
        end
    end

    // Next state and output decode
    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        rsp_rdata_o  = '0;
        sram_addr_o  = '0;
        sram_wd_o    = '0;
        sram_read_o  = 1'b0;
        sram_write_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (!req_write_i) begin
                        state_d = S_RD;
                    end else if (mask_zero) begin
                        // Nothing to write; stay ready for the next request.
                        state_d = S_IDLE;
`ifdef SRAMCTL_FULLWR_BYPASS_EN
                    end else if (mask_full) begin
                        state_d = S_WR;
`endif
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                sram_read_o = 1'b1;
                sram_addr_o = addr_q;
                state_d     = write_q ? S_MERGE : S_RESP;
            end
            S_RESP: begin
                // No read is issued here, so the bank output stays put.
                rsp_valid_o = 1'b1;
                rsp_rdata_o = sram_dataout_i;
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            S_MERGE: begin
                sram_write_o = 1'b1;
                sram_addr_o  = addr_q;
                sram_wd_o    = merged;
                state_d      = S_IDLE;
            end
            S_WR: begin
                sram_write_o = 1'b1;
                sram_addr_o  = addr_q;
                sram_wd_o    = wdata_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifndef SRAMCTL_FULLWR_BYPASS_EN
    // Full-mask detection only steers the bypass path.
    logic unused_mask_full;
    assign unused_mask_full = mask_full;
`endif

    assign sram_banksel_o = sram_read_o | sram_write_o;

endmodule
